// File: rtl/battlechip_ai_pkg.sv
// -----------------------------------------------------------------------------
// battlechip_ai_pkg
// Shared definitions for the AI targeting blocks: grid geometry, density
// width, the target-selector FSM states, the registered target record and
// a divide-free index to (x, y) conversion helper.
// Configuration macro used by the consumers of this package: AI_PARITY_EN.
// -----------------------------------------------------------------------------
package battlechip_ai_pkg;

   localparam int GRID_DIM  = 10;
   localparam int NUM_CELLS = GRID_DIM * GRID_DIM;
   localparam int DENS_W    = 6;
   localparam int IDX_W     = 7;
   localparam int COORD_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } sel_state_t;

   typedef struct packed {
      logic [IDX_W-1:0]   idx;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [DENS_W-1:0]  dens;
      logic               none;
   } target_t;

   // Row is found with a chain of constant compares against row base
   // offsets, so no divider is built. Returns {y, x}.
   function automatic logic [2*COORD_W-1:0] idx_to_xy(input logic [IDX_W-1:0] idx);
      logic [COORD_W-1:0] row;
      logic [IDX_W-1:0]   base;
      row  = '0;
      base = '0;
      for (int r = 1; r < GRID_DIM; r++) begin
         if (idx >= IDX_W'(r * GRID_DIM)) begin
            row  = COORD_W'(r);
            base = IDX_W'(r * GRID_DIM);
         end
      end
      return {row, COORD_W'(idx - base)};
   endfunction

endpackage

// File: rtl/ai_best_tracker.sv
// -----------------------------------------------------------------------------
// ai_best_tracker
// Holds one running maximum over a stream of candidate cells. A candidate
// replaces the held best when it is valid and either nothing is held yet or
// its density is strictly greater, so ties keep the earliest index.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        drop the held best (start of a new scan)
//   cand_valid   candidate is eligible this cycle
//   cand_idx     candidate cell index
//   cand_dens    candidate density
//   found        a best is held
//   best_idx     index of the held best
//   best_dens    density of the held best
// -----------------------------------------------------------------------------
module ai_best_tracker
   import battlechip_ai_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              cand_valid,
   input  logic [IDX_W-1:0]  cand_idx,
   input  logic [DENS_W-1:0] cand_dens,
   output logic              found,
   output logic [IDX_W-1:0]  best_idx,
   output logic [DENS_W-1:0] best_dens
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         found     <= 1'b0;
         best_idx  <= '0;
         best_dens <= '0;
      end else if (clear) begin
         found     <= 1'b0;
         best_idx  <= '0;
         best_dens <= '0;
      end else if (cand_valid && (!found || (cand_dens > best_dens))) begin
         found     <= 1'b1;
         best_idx  <= cand_idx;
         best_dens <= cand_dens;
      end
   end

endmodule

// File: rtl/ai_target_select.sv
// -----------------------------------------------------------------------------
// ai_target_select
// Scans the density map one cell per cycle in row-major order after a start
// pulse and offers the highest-density unfired cell as the next shot on a
// valid/ready handshake. The density map and fired flags are not captured;
// they must stay stable from start until target_valid.
// Optional feature macro: AI_PARITY_EN adds a checkerboard tracker over cells
// with even (x+y); its result takes priority whenever it found a cell.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             scan request, honoured only while idle
//   density           per-cell density, index y*GRID_DIM + x
//   fired             per-cell already-shot flag
//   busy              scan running or target pending
//   target_valid      target outputs hold a result
//   target_ready      consumer accepts the target
//   target_idx/x/y    selected cell and its coordinates
//   target_density    density of the selected cell
//   no_target         no unfired cell existed (qualified by target_valid)
// Overrides of DENS_W must match the package DENS_W.
// -----------------------------------------------------------------------------
module ai_target_select
   import battlechip_ai_pkg::*;
#(
   parameter int GRID_DIM = 10,
   parameter int DENS_W   = 6
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       start,
   input  logic [GRID_DIM*GRID_DIM-1:0][DENS_W-1:0]   density,
   input  logic [GRID_DIM*GRID_DIM-1:0]               fired,
   output logic                                       busy,
   output logic                                       target_valid,
   input  logic                                       target_ready,
   output logic [IDX_W-1:0]                           target_idx,
   output logic [COORD_W-1:0]                         target_x,
   output logic [COORD_W-1:0]                         target_y,
   output logic [DENS_W-1:0]                          target_density,
   output logic                                       no_target
);

   localparam logic [COORD_W-1:0] LAST_COORD = COORD_W'(GRID_DIM - 1);

   sel_state_t          state_q, state_d;
   logic [COORD_W-1:0]  x_q, y_q;
   logic                scan_end_q;
   target_t             tgt_q;
   logic                valid_q;

   logic [IDX_W-1:0]    cur_idx;
   logic [DENS_W-1:0]   cur_dens;
   logic                eval_cell, eligible, clear;

   logic                any_found;
   logic [IDX_W-1:0]    any_idx;
   logic [DENS_W-1:0]   any_dens;

   logic                sel_found;
   logic [IDX_W-1:0]    sel_idx;
   logic [DENS_W-1:0]   sel_dens;
   logic [2*COORD_W-1:0] sel_xy;

   // Current cell comes from the row/column counters; only a constant
   // multiply is needed, never a divide.
   assign cur_idx   = IDX_W'(y_q) * IDX_W'(GRID_DIM) + IDX_W'(x_q);
   assign cur_dens  = density[cur_idx];
   assign eval_cell = (state_q == SCAN) && !scan_end_q;
   assign eligible  = eval_cell && !fired[cur_idx];
   assign clear     = (state_q == IDLE) && start;

   ai_best_tracker u_any (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .cand_valid (eligible),
      .cand_idx   (cur_idx),
      .cand_dens  (cur_dens),
      .found      (any_found),
      .best_idx   (any_idx),
      .best_dens  (any_dens)
   );

`ifdef AI_PARITY_EN
   logic                even_cell;
   logic                par_found;
   logic [IDX_W-1:0]    par_idx;
   logic [DENS_W-1:0]   par_dens;

   // (x+y) is even exactly when the low bits of x and y agree.
   assign even_cell = ~(x_q[0] ^ y_q[0]);

   ai_best_tracker u_par (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .cand_valid (eligible && even_cell),
      .cand_idx   (cur_idx),
      .cand_dens  (cur_dens),
      .found      (par_found),
      .best_idx   (par_idx),
      .best_dens  (par_dens)
   );

   assign sel_found = par_found | any_found;
   assign sel_idx   = par_found ? par_idx  : any_idx;
   assign sel_dens  = par_found ? par_dens : any_dens;
`else
   assign sel_found = any_found;
   assign sel_idx   = any_idx;
   assign sel_dens  = any_dens;
`endif

   assign sel_xy = idx_to_xy(sel_idx);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state; SCAN lasts one extra cycle after cell 99 so the
   // tracker holds its final value when the target is registered.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SCAN;
         SCAN:    if (scan_end_q) state_d = DONE;
         DONE:    if (valid_q && target_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Scan counters and target register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q        <= '0;
         y_q        <= '0;
         scan_end_q <= 1'b0;
         tgt_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  x_q        <= '0;
                  y_q        <= '0;
                  scan_end_q <= 1'b0;
               end
            end
            SCAN: begin
               if (!scan_end_q) begin
                  if (x_q == LAST_COORD) begin
                     x_q <= '0;
                     if (y_q == LAST_COORD) scan_end_q <= 1'b1;
                     else                   y_q <= y_q + 1'b1;
                  end else begin
                     x_q <= x_q + 1'b1;
                  end
               end else begin
                  valid_q <= 1'b1;
                  if (sel_found) begin
                     tgt_q <= '{idx: sel_idx, x: sel_xy[COORD_W-1:0],
                                y: sel_xy[2*COORD_W-1:COORD_W],
                                dens: sel_dens, none: 1'b0};
                  end else begin
                     tgt_q <= '{idx: '0, x: '0, y: '0, dens: '0, none: 1'b1};
                  end
               end
            end
            DONE: begin
               if (valid_q && target_ready) valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy           = (state_q != IDLE);
   assign target_valid   = valid_q;
   assign target_idx     = tgt_q.idx;
   assign target_x       = tgt_q.x;
   assign target_y       = tgt_q.y;
   assign target_density = tgt_q.dens;
   assign no_target      = tgt_q.none;

endmodule

// File: tb/tb_ai_target_select.sv
// -----------------------------------------------------------------------------
// tb_ai_target_select
// Self-checking bench for ai_target_select. Directed scenarios plus
// randomized density/fired maps; expected targets come from a reference
// model that picks the maximum density over the unfired pool (restricted to
// even-parity cells when AI_PARITY_EN is defined and such cells exist) and
// then the lowest index holding that maximum.
// -----------------------------------------------------------------------------
module tb_ai_target_select;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              target_ready = 1'b0;
   logic [99:0][5:0]  dens_v;
   logic [99:0]       fired_v;
   logic              busy, target_valid, no_target;
   logic [6:0]        target_idx;
   logic [3:0]        target_x, target_y;
   logic [5:0]        target_density;

   int checks = 0;
   int errors = 0;
   int e_idx, e_dens;
   bit e_none;

   ai_target_select dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .density        (dens_v),
      .fired          (fired_v),
      .busy           (busy),
      .target_valid   (target_valid),
      .target_ready   (target_ready),
      .target_idx     (target_idx),
      .target_x       (target_x),
      .target_y       (target_y),
      .target_density (target_density),
      .no_target      (no_target)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference selection over the current stimulus maps.
   function automatic void model();
      int pool[$];
      int best;
`ifdef AI_PARITY_EN
      int even[$];
`endif
      pool = {};
      for (int i = 0; i < 100; i++) if (!fired_v[i]) pool.push_back(i);
`ifdef AI_PARITY_EN
      even = {};
      foreach (pool[k]) if (((pool[k] % 10) + (pool[k] / 10)) % 2 == 0) even.push_back(pool[k]);
      if (even.size() > 0) pool = even;
`endif
      e_idx = 0; e_dens = 0; e_none = 1'b1;
      if (pool.size() > 0) begin
         best = 0;
         foreach (pool[k]) if (int'(dens_v[pool[k]]) > best) best = int'(dens_v[pool[k]]);
         e_none = 1'b0;
         e_dens = best;
         e_idx  = -1;
         foreach (pool[k]) if (e_idx < 0 && int'(dens_v[pool[k]]) == best) e_idx = pool[k];
      end
   endfunction

   task automatic check_target(input string tag);
      check({tag, ".valid"}, int'(target_valid), 1);
      check({tag, ".idx"},   int'(target_idx), e_idx);
      check({tag, ".x"},     int'(target_x), e_idx % 10);
      check({tag, ".y"},     int'(target_y), e_idx / 10);
      check({tag, ".dens"},  int'(target_density), e_dens);
      check({tag, ".none"},  int'(no_target), int'(e_none));
      check({tag, ".busy"},  int'(busy), 1);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, ".busy"},  int'(busy), 0);
      check({tag, ".valid"}, int'(target_valid), 0);
      check({tag, ".idx"},   int'(target_idx), 0);
      check({tag, ".x"},     int'(target_x), 0);
      check({tag, ".y"},     int'(target_y), 0);
      check({tag, ".dens"},  int'(target_density), 0);
      check({tag, ".none"},  int'(no_target), 0);
   endtask

   // One full request: start, measure latency, verify target, optionally
   // hold it with ready low (poking start meanwhile), then handshake.
   task automatic do_scan(input string tag, input bit ready_early, input int hold, input bit poke);
      int n;
      model();
      @(negedge clk);
      start = 1'b1;
      target_ready = ready_early;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check({tag, ".busy_scan"}, int'(busy), 1);
      for (n = 1; n <= 200; n++) begin
         @(posedge clk);
         @(negedge clk);
         start = poke && (n == 30);
         if (target_valid) break;
      end
      start = 1'b0;
      check({tag, ".latency"}, n, 101);
      if (!target_valid) begin
         target_ready = 1'b0;
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         return;
      end
      check_target(tag);
      if (!ready_early) begin
         for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = poke;
            check_target({tag, ".hold"});
         end
         target_ready = 1'b1;
         start = poke;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      target_ready = 1'b0;
      check({tag, ".post_valid"}, int'(target_valid), 0);
      check({tag, ".post_busy"}, int'(busy), 0);
      @(posedge clk);
      @(negedge clk);
      check({tag, ".idle_busy"}, int'(busy), 0);
   endtask

   initial begin
      for (int i = 0; i < 100; i++) dens_v[i] = 6'd0;
      fired_v = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_cleared("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_cleared("after_reset");

      // Single peak at 57
      for (int i = 0; i < 100; i++) dens_v[i] = 6'd1;
      dens_v[57] = 6'd20;
      do_scan("peak57", 1'b0, 2, 1'b0);

      // Tie between 12 and 80; ready held high in advance
      for (int i = 0; i < 100; i++) dens_v[i] = 6'd0;
      dens_v[12] = 6'd9;
      dens_v[80] = 6'd9;
      do_scan("tie", 1'b1, 0, 1'b0);

      // Highest cell already fired
      for (int i = 0; i < 100; i++) dens_v[i] = 6'd2;
      dens_v[33] = 6'd40;
      dens_v[34] = 6'd39;
      fired_v[33] = 1'b1;
      do_scan("fired33", 1'b0, 1, 1'b1);

      // Every cell fired: no target, held 5 cycles with start poked
      fired_v = '1;
      do_scan("all_fired", 1'b0, 5, 1'b1);

      // Reset in the middle of a scan
      fired_v = '0;
      for (int i = 0; i < 100; i++) dens_v[i] = 6'(i % 7);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (50) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_cleared("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_cleared("mid_reset_rel");
      do_scan("after_mid_reset", 1'b0, 1, 1'b0);

      // Randomized maps
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 100; i++) begin
            dens_v[i]  = (r == 5) ? 6'd0 : 6'($urandom_range(0, (r < 3) ? 7 : 63));
            fired_v[i] = ($urandom_range(0, 3) == 0);
         end
         do_scan($sformatf("rand%0d", r), r[0], r % 3, r[1]);
      end

      // Only cell 97 left unfired
      fired_v = '1;
      fired_v[97] = 1'b0;
      for (int i = 0; i < 100; i++) dens_v[i] = 6'd63;
      dens_v[97] = 6'd0;
      do_scan("last97", 1'b0, 0, 1'b0);

`ifdef AI_PARITY_EN
      fired_v = '0;
      for (int i = 0; i < 100; i++) dens_v[i] = 6'd0;
      dens_v[1] = 6'd30;
      dens_v[0] = 6'd5;
      do_scan("parity_even", 1'b0, 1, 1'b0);
      for (int i = 0; i < 100; i++) fired_v[i] = (((i % 10) + (i / 10)) % 2 == 0);
      do_scan("parity_odd", 1'b0, 1, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ai_target_select.md
# ai_target_select

Downstream consumer of the AI density map. On a `start` pulse it scans all 100 grid cells, one per cycle, and selects the unfired cell with the highest placement density. It presents that cell as the AI's next shot on a valid/ready handshake to the game controller. The block sits between the density generator (100 × 6-bit density map) and the move-issue logic.

## Interface
Parameters:
- `GRID_DIM`, 10, board side length; cell count is `GRID_DIM*GRID_DIM`.
- `DENS_W`, 6, width of each density entry.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request to begin a scan; honoured only in IDLE.
- `density`  in  [99:0][DENS_W-1:0]  per-cell density; index i = y*10 + x.
- `fired`  in  100  per-cell already-shot flag, same indexing.
- `busy`  out  1  high in SCAN and DONE.
- `target_valid`  out  1  selected target available.
- `target_ready`  in  1  consumer accepts target.
- `target_idx`  out  7  selected cell index, 0–99.
- `target_x`  out  4  column, `idx % 10`.
- `target_y`  out  4  row, `idx / 10`.
- `target_density`  out  DENS_W  density of the selected cell.
- `no_target`  out  1  no unfired cell exists; valid only with `target_valid`.

## Operation
- FSM states and transitions:
  - IDLE → SCAN on `start`.
  - SCAN → DONE after evaluating cell 99.
  - DONE → IDLE on `target_valid && target_ready`.
- Scan state:
  - Row counter `y` and column counter `x` run in row-major order. Column wraps 9 → 0 with a row increment.
  - The current index is `y*10 + x`. No divide or modulo in the datapath.
- Eligibility: `fired[i] == 0`.
- Update rule: the best register is replaced when the cell is eligible and either no candidate is held yet or `density[i] > best_density`.
  - Comparison is strict, so on ties the lowest index wins.
  - When all eligible cells are zero, the first unfired cell is chosen.
- No eligible cell after the full scan:
  - `no_target` = 1.
  - `target_idx`, `target_x`, `target_y`, `target_density` = 0.
- `density` and `fired` must be held stable from `start` until `target_valid`. The block does not snapshot them.
- Once `target_valid` is high, all target outputs are registered and stable until the handshake completes.
- `start` is ignored in SCAN and DONE. No queuing.

## Timing
- Reset value of all outputs and internal registers is 0. FSM resets to IDLE.
- `start` sampled high at edge 0: cell 0 is evaluated in the cycle after edge 0, and cell 99 in the 100th cycle.
- `target_valid` rises after edge 101, giving a latency of 101 cycles from the `start` edge.
- Handshake:
  - Completes on the rising edge where `target_valid && target_ready`.
  - `target_valid` drops the following cycle.
  - `target_ready` held high in advance gives a one-cycle DONE.
- `start` in the same cycle as the handshake is ignored. A new request needs at least one IDLE cycle.
- Reset asserted mid-scan or in DONE returns the block to IDLE immediately, clears all outputs, and drops any pending target.

## Configuration
- `AI_PARITY_EN` defined: add checkerboard hunt mode.
  - Two best trackers run in parallel: parity-best over unfired cells with `(x+y)` even, and any-best over all unfired cells.
  - At the end of the scan the parity-best is used if one was found, otherwise the any-best. Latency is unchanged.
- `AI_PARITY_EN` undefined: only the any-best tracker exists. Behaviour is as in Operation.

## Structure
- Shared package `battlechip_ai_pkg`:
  - Constants `GRID_DIM`, `NUM_CELLS`, `DENS_W`.
  - FSM state enum `sel_state_t` (IDLE, SCAN, DONE).
  - Struct `target_t` with fields `{idx, x, y, dens, none}`.
- Sub-module `ai_best_tracker` holds one running best. It is instantiated once, or twice with `AI_PARITY_EN`. Its I/O:
  - Inputs: clear, candidate valid, index, density.
  - Outputs: found, best index, best density.

## Test plan
- All `fired` = 0; density 1 everywhere except `density[57]` = 20 → `target_idx` = 57, x = 7, y = 5, dens = 20, valid at cycle 101.
- `density[12]` = `density[80]` = 9 (tie max) → `target_idx` = 12.
- `density[33]` = 40 with `fired[33]` = 1; `density[34]` = 39 → `target_idx` = 34.
- All `fired` = 1 → `no_target` = 1 with `target_idx` = 0; `target_ready` low for 5 cycles keeps outputs stable, then handshake returns to IDLE.
- Reset pulse at cycle 50 of a scan → all outputs 0, IDLE; a fresh `start` gives the correct result after 101 cycles.
- `AI_PARITY_EN`: `density[1]` = 30 (odd parity), `density[0]` = 5 → `target_idx` = 0. Same test with all even-parity cells fired → `target_idx` = 1.
